instruction_memory_sync: RTL and testbench

INSTRUCTION_MEMORY_SYNC -- requirements
Module: instruction_memory_sync

---
 rtl/instruction_memory_sync.sv | 56 +++++
 tb/tb_instruction_memory_sync.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/instruction_memory_sync.sv
// instruction_memory_sync: single-cycle instruction fetch memory with a one-entry response register, fault detection and a program-load write port
module instruction_memory_sync #(
  parameter int unsigned DEPTH = 64,
  parameter logic [31:0] NOP_WORD = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  input  logic        wr_en,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data,
  output logic [31:0] fetch_cnt
);
  localparam int AW = $clog2(DEPTH);
  logic [31:0] r_mem [DEPTH] = '{default: NOP_WORD};
  logic        r_rsp_valid;
  logic [31:0] r_rsp_data;
  logic        r_rsp_err;
  logic [31:0] r_cnt;
  logic        w_accept;
  logic        w_fault;
  logic        w_wr_ok;
  // Upper index bits must be zero so out-of-range addresses never alias onto real words
  assign w_fault   = (req_addr[1:0] != 2'b00) || (req_addr[31:AW+2] != '0);
  assign w_wr_ok   = wr_en && (wr_addr[1:0] == 2'b00) && (wr_addr[31:AW+2] == '0);
  assign req_ready = !reset && (!r_rsp_valid || rsp_ready);
  assign w_accept  = req_valid && req_ready;
  always_ff @(posedge clk) begin
    if (w_wr_ok) r_mem[wr_addr[AW+1:2]] <= wr_data;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
      r_cnt       <= '0;
    end else if (w_accept) begin
      r_rsp_valid <= 1'b1;
      r_rsp_data  <= w_fault ? NOP_WORD : r_mem[req_addr[AW+1:2]];
      r_rsp_err   <= w_fault;
      r_cnt       <= r_cnt + 32'd1;
    end else if (rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;
  assign fetch_cnt = r_cnt;
endmodule

// File: tb/tb_instruction_memory_sync.sv
// tb_instruction_memory_sync: directed self-checking bench for instruction_memory_sync
module tb_instruction_memory_sync;
  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [31:0] fetch_cnt;
  int checks = 0;
  int failures = 0;
  logic [31:0] exp_cnt = 0;

  instruction_memory_sync dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; req_valid = 1'b1; req_addr = 32'h0; rsp_ready = 1'b1;
    wr_en = 1'b0; wr_addr = 32'h0; wr_data = 32'h0;
    tick; tick;
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b exp=0", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", rsp_valid); end
    checks++; if (rsp_data !== 32'h0) begin failures++; $display("FAIL rst_data got=%h exp=00000000", rsp_data); end
    checks++; if (rsp_err !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", rsp_err); end
    checks++; if (fetch_cnt !== 32'h0) begin failures++; $display("FAIL rst_cnt got=%0d exp=0", fetch_cnt); end
    req_valid = 1'b0; reset = 1'b0;
    tick;
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_no_accept got=%b exp=0", rsp_valid); end
  endtask

  task automatic test_power_up;
    req_valid = 1'b1; req_addr = 32'h0; rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL pu_ready got=%b exp=1", req_ready); end
    tick; exp_cnt++; req_valid = 1'b0;
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL pu_valid got=%b exp=1", rsp_valid); end
    checks++; if (rsp_data !== 32'h00000013) begin failures++; $display("FAIL pu_data got=%h exp=00000013", rsp_data); end
    checks++; if (rsp_err !== 1'b0) begin failures++; $display("FAIL pu_err got=%b exp=0", rsp_err); end
    checks++; if (fetch_cnt !== exp_cnt) begin failures++; $display("FAIL pu_cnt got=%0d exp=%0d", fetch_cnt, exp_cnt); end
    tick;
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL pu_drop got=%b exp=0", rsp_valid); end
    checks++; if (rsp_data !== 32'h00000013) begin failures++; $display("FAIL pu_hold got=%h exp=00000013", rsp_data); end
  endtask

  task automatic test_load_fetch;
    wr_en = 1'b1; wr_addr = 32'h4; wr_data = 32'h00A5A023;
    tick; wr_en = 1'b0;
    req_valid = 1'b1; req_addr = 32'h4; rsp_ready = 1'b1;
    tick; exp_cnt++; req_valid = 1'b0;
    checks++; if (rsp_data !== 32'h00A5A023) begin failures++; $display("FAIL lf_data got=%h exp=00a5a023", rsp_data); end
    checks++; if (rsp_err !== 1'b0) begin failures++; $display("FAIL lf_err got=%b exp=0", rsp_err); end
    tick;
  endtask

  task automatic test_faults;
    req_valid = 1'b1; req_addr = 32'h102; rsp_ready = 1'b1;
    tick; exp_cnt++;
    checks++; if (rsp_err !== 1'b1) begin failures++; $display("FAIL mis_err got=%b exp=1", rsp_err); end
    checks++; if (rsp_data !== 32'h00000013) begin failures++; $display("FAIL mis_data got=%h exp=00000013", rsp_data); end
    req_addr = 32'h100;
    tick; exp_cnt++;
    checks++; if (rsp_err !== 1'b1) begin failures++; $display("FAIL oor_err got=%b exp=1", rsp_err); end
    checks++; if (rsp_data !== 32'h00000013) begin failures++; $display("FAIL oor_data got=%h exp=00000013", rsp_data); end
    req_addr = 32'h6;
    tick; exp_cnt++;
    checks++; if (rsp_err !== 1'b1 || rsp_data !== 32'h00000013) begin failures++; $display("FAIL mis6 got=%b/%h exp=1/00000013", rsp_err, rsp_data); end
    req_valid = 1'b0;
    wr_en = 1'b1; wr_addr = 32'h100; wr_data = 32'hDEADBEEF;
    tick;
    wr_addr = 32'h1; wr_data = 32'hBADBAD00;
    tick;
    wr_addr = 32'hFC; wr_data = 32'h0FC0FC00;
    tick; wr_en = 1'b0;
    req_valid = 1'b1; req_addr = 32'h0;
    tick; exp_cnt++;
    checks++; if (rsp_data !== 32'h00000013 || rsp_err !== 1'b0) begin failures++; $display("FAIL word0_kept got=%h/%b exp=00000013/0", rsp_data, rsp_err); end
    req_addr = 32'hFC;
    tick; exp_cnt++;
    checks++; if (rsp_data !== 32'h0FC0FC00 || rsp_err !== 1'b0) begin failures++; $display("FAIL last_word got=%h/%b exp=0fc0fc00/0", rsp_data, rsp_err); end
    checks++; if (fetch_cnt !== exp_cnt) begin failures++; $display("FAIL fault_cnt got=%0d exp=%0d", fetch_cnt, exp_cnt); end
    req_valid = 1'b0;
    tick;
  endtask

  task automatic test_back_to_back;
    rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'h0;
    #1;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL bp_ready0 got=%b exp=1", req_ready); end
    tick; exp_cnt++;
    req_addr = 32'h4;
    #1;
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL bp_ready1 got=%b exp=0", req_ready); end
    for (int i = 0; i < 2; i++) begin
      tick;
      checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h00000013 || rsp_err !== 1'b0) begin failures++; $display("FAIL bp_hold%0d got=%b/%h/%b exp=1/00000013/0", i, rsp_valid, rsp_data, rsp_err); end
      checks++; if (fetch_cnt !== exp_cnt) begin failures++; $display("FAIL bp_cnt%0d got=%0d exp=%0d", i, fetch_cnt, exp_cnt); end
    end
    rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL bp_ready2 got=%b exp=1", req_ready); end
    tick; exp_cnt++; req_valid = 1'b0;
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h00A5A023) begin failures++; $display("FAIL bp_second got=%b/%h exp=1/00a5a023", rsp_valid, rsp_data); end
    checks++; if (fetch_cnt !== exp_cnt) begin failures++; $display("FAIL bp_cnt2 got=%0d exp=%0d", fetch_cnt, exp_cnt); end
    tick;
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL bp_drop got=%b exp=0", rsp_valid); end
  endtask

  task automatic test_collision;
    wr_en = 1'b1; wr_addr = 32'h8; wr_data = 32'h0005A683;
    tick;
    wr_data = 32'h12345678; req_valid = 1'b1; req_addr = 32'h8; rsp_ready = 1'b1;
    tick; exp_cnt++; wr_en = 1'b0;
    checks++; if (rsp_data !== 32'h0005A683) begin failures++; $display("FAIL col_old got=%h exp=0005a683", rsp_data); end
    tick; exp_cnt++; req_valid = 1'b0;
    checks++; if (rsp_data !== 32'h12345678) begin failures++; $display("FAIL col_new got=%h exp=12345678", rsp_data); end
    tick;
  endtask

  task automatic test_reset_mid;
    rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'h4;
    tick; req_valid = 1'b0;
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL rm_pending got=%b exp=1", rsp_valid); end
    reset = 1'b1; wr_en = 1'b1; wr_addr = 32'hC; wr_data = 32'hCAFEF00D;
    tick; reset = 1'b0; wr_en = 1'b0; exp_cnt = 0;
    checks++; if (rsp_valid !== 1'b0 || rsp_data !== 32'h0 || rsp_err !== 1'b0) begin failures++; $display("FAIL rm_clear got=%b/%h/%b exp=0/00000000/0", rsp_valid, rsp_data, rsp_err); end
    checks++; if (fetch_cnt !== 32'h0) begin failures++; $display("FAIL rm_cnt got=%0d exp=0", fetch_cnt); end
    tick;
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rm_no_replay got=%b exp=0", rsp_valid); end
    rsp_ready = 1'b1; req_valid = 1'b1; req_addr = 32'h4;
    tick; exp_cnt++;
    checks++; if (rsp_data !== 32'h00A5A023) begin failures++; $display("FAIL rm_kept4 got=%h exp=00a5a023", rsp_data); end
    req_addr = 32'hC;
    tick; exp_cnt++;
    checks++; if (rsp_data !== 32'hCAFEF00D) begin failures++; $display("FAIL rm_wr_in_reset got=%h exp=cafef00d", rsp_data); end
    req_addr = 32'h8;
    tick; exp_cnt++; req_valid = 1'b0;
    checks++; if (rsp_data !== 32'h12345678) begin failures++; $display("FAIL rm_kept8 got=%h exp=12345678", rsp_data); end
    checks++; if (fetch_cnt !== exp_cnt) begin failures++; $display("FAIL rm_cnt_after got=%0d exp=%0d", fetch_cnt, exp_cnt); end
    tick;
  endtask

  initial begin
    test_reset;
    test_power_up;
    test_load_fetch;
    test_faults;
    test_back_to_back;
    test_collision;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
